req_gnt_initiator: RTL and testbench

Requesting side of the single-cycle req/gnt handshake: issues a one-cycle `req` pulse on command, waits for `gnt` inside a bounded window, retries after a back-off on timeout, and reports success or failure. It sits in front of any granting block on this interface and keeps `req` legal by construction: never high on two consecutive cycles, never re-issued while a grant is outstanding. It also keeps saturating statistics.

---
 rtl/req_gnt_pkg.sv | 33 +++
 rtl/sat_counter.sv | 30 +++
 rtl/req_gnt_initiator.sv | 157 +++++++++++++++
 tb/tb_req_gnt_initiator.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_gnt_pkg.sv
// ---------------------------------------------------------------------------
// req_gnt_pkg
//   Shared types and default constants for the requesting side of the
//   single-cycle req/gnt handshake.
//
//   Contents:
//     req_state_t      - FSM state encoding for req_gnt_initiator
//     DEF_TIMEOUT      - default WAIT window length (cycles)
//     DEF_MAX_RETRY    - default number of re-issues after a timeout
//     DEF_BACKOFF      - default idle gap between timeout and next req
//     DEF_CNT_W        - default statistics counter width
//     bits_for()       - width needed to count 0 .. n-1 (at least 1 bit)
// ---------------------------------------------------------------------------
package req_gnt_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_WAIT    = 2'd2,
        ST_BACKOFF = 2'd3
    } req_state_t;

    localparam int DEF_TIMEOUT   = 8;
    localparam int DEF_MAX_RETRY = 2;
    localparam int DEF_BACKOFF   = 4;
    localparam int DEF_CNT_W     = 16;

    // Width of a counter that must hold the values 0 .. n-1.
    function automatic int bits_for(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage : req_gnt_pkg

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
//   Up-counter that sticks at all-ones instead of wrapping.
//
//   Ports:
//     clk   in   1      clock, rising edge
//     clr   in   1      synchronous clear, highest priority
//     inc   in   1      increment request
//     q     out  WIDTH  current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] q
);

    // NOTE: sequential state is always written with non-blocking (<=)
    // assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + WIDTH'(1);
        end
    end

endmodule : sat_counter

// File: rtl/req_gnt_initiator.sv
// ---------------------------------------------------------------------------
// req_gnt_initiator
//   Requesting side of the single-cycle req/gnt handshake. On an accepted
//   start it pulses req for one cycle, then waits up to TIMEOUT cycles for
//   gnt. On timeout it backs off for BACKOFF cycles and retries, up to
//   MAX_RETRY re-issues, then reports err. A grant inside the window
//   reports done. gnt seen outside the window is flagged as stray.
//   req can never be high on two consecutive cycles because REQ always
//   moves on to WAIT.
//
//   Ports:
//     clk          in   1      clock, rising edge
//     reset        in   1      synchronous, active-high reset
//     start        in   1      command strobe, only sampled when idle
//     gnt          in   1      grant from responder
//     req          out  1      request pulse, one cycle per attempt
//     busy         out  1      high from accepted start until done/err
//     done         out  1      one-cycle pulse, grant received
//     err          out  1      one-cycle pulse, all attempts timed out
//     stray        out  1      one-cycle pulse, gnt seen outside WAIT
//     grant_cnt    out  CNT_W  accepted grants, saturating
//     timeout_cnt  out  CNT_W  timed-out attempts, saturating
// ---------------------------------------------------------------------------
module req_gnt_initiator
    import req_gnt_pkg::*;
#(
    parameter int TIMEOUT   = DEF_TIMEOUT,
    parameter int MAX_RETRY = DEF_MAX_RETRY,
    parameter int BACKOFF   = DEF_BACKOFF,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             gnt,
    output logic             req,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             stray,
    output logic [CNT_W-1:0] grant_cnt,
    output logic [CNT_W-1:0] timeout_cnt
);

    // One timer is shared by WAIT and BACKOFF; it only ever counts to the
    // larger of the two lengths minus one.
    localparam int TW = bits_for((TIMEOUT > BACKOFF) ? TIMEOUT : BACKOFF);
    localparam int RW = bits_for(MAX_RETRY + 1);

    req_state_t    state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          done_d, err_d, stray_d;
    logic          grant_inc, timeout_inc;

    // NOTE: every signal written here gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        retry_d     = retry_q;
        done_d      = 1'b0;
        err_d       = 1'b0;
        grant_inc   = 1'b0;
        timeout_inc = 1'b0;
        // Only WAIT consumes a grant; anywhere else it is unexpected.
        stray_d     = gnt && (state_q != ST_WAIT);

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_REQ;
                    retry_d = '0;
                end
            end

            ST_REQ: begin
                state_d = ST_WAIT;
                timer_d = '0;
            end

            ST_WAIT: begin
                // A grant on the last window cycle beats the timeout.
                if (gnt) begin
                    state_d   = ST_IDLE;
                    done_d    = 1'b1;
                    grant_inc = 1'b1;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    timeout_inc = 1'b1;
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d = retry_q + RW'(1);
                        timer_d = '0;
                        state_d = ST_BACKOFF;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            ST_BACKOFF: begin
                if (timer_q == TW'(BACKOFF - 1)) begin
                    state_d = ST_REQ;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // req and busy are registered copies of the next state, so they line up
    // with the state they describe without any combinational output path.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            retry_q <= '0;
            req     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            stray   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            req     <= (state_d == ST_REQ);
            busy    <= (state_d != ST_IDLE);
            done    <= done_d;
            err     <= err_d;
            stray   <= stray_d;
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_grant_cnt (
        .clk (clk),
        .clr (reset),
        .inc (grant_inc),
        .q   (grant_cnt)
    );

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_timeout_cnt (
        .clk (clk),
        .clr (reset),
        .inc (timeout_inc),
        .q   (timeout_cnt)
    );

endmodule : req_gnt_initiator

// File: tb/tb_req_gnt_initiator.sv
// ---------------------------------------------------------------------------
// tb_req_gnt_initiator
//   Directed bench for req_gnt_initiator at default parameters
//   (TIMEOUT=8, MAX_RETRY=2, BACKOFF=4, CNT_W=16). Inputs change and
//   outputs are observed 1 ns after each rising edge, so every observation
//   shows the registered outputs of the cycle that edge started.
// ---------------------------------------------------------------------------
module tb_req_gnt_initiator;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        gnt = 1'b0;
    logic        req, busy, done, err, stray;
    logic [15:0] grant_cnt, timeout_cnt;
    logic [4:0]  obs;

    int tests = 0;
    int fails = 0;

    assign obs = {req, busy, done, err, stray};

    always #5 clk = ~clk;

    req_gnt_initiator #(
        .TIMEOUT   (8),
        .MAX_RETRY (2),
        .BACKOFF   (4),
        .CNT_W     (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .gnt         (gnt),
        .req         (req),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .stray       (stray),
        .grant_cnt   (grant_cnt),
        .timeout_cnt (timeout_cnt)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        start = 1'b0;
        gnt   = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // obs is {req,busy,done,err,stray}
    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            start = ~start;
            gnt   = ~gnt;
            tick();
            tests++;
            if (obs !== 5'b00000 || grant_cnt !== 16'd0 || timeout_cnt !== 16'd0) begin
                fails++;
                $display("FAIL reset_cycle%0d obs=%b gc=%0d tc=%0d want obs=00000 gc=0 tc=0",
                         i, obs, grant_cnt, timeout_cnt);
            end
        end
        reset = 1'b0;
        start = 1'b0;
        gnt   = 1'b0;
        tick();
        tests++;
        if (obs !== 5'b00000) begin
            fails++;
            $display("FAIL reset_release obs=%b want 00000", obs);
        end
    endtask

    task automatic test_single_grant();
        apply_reset();
        start = 1'b1;
        tick();                      // REQ cycle
        start = 1'b0;
        tests++;
        if (obs !== 5'b11000) begin
            fails++;
            $display("FAIL single_req obs=%b want 11000", obs);
        end
        tick();                      // WAIT 1
        tests++;
        if (obs !== 5'b01000) begin
            fails++;
            $display("FAIL single_wait1 obs=%b want 01000", obs);
        end
        tick();                      // WAIT 2: grant two cycles after req
        gnt = 1'b1;
        tick();                      // done cycle
        gnt = 1'b0;
        tests++;
        if (obs !== 5'b00100 || grant_cnt !== 16'd1 || timeout_cnt !== 16'd0) begin
            fails++;
            $display("FAIL single_done obs=%b gc=%0d tc=%0d want obs=00100 gc=1 tc=0",
                     obs, grant_cnt, timeout_cnt);
        end
        tick();
        tests++;
        if (obs !== 5'b00000) begin
            fails++;
            $display("FAIL single_after obs=%b want 00000", obs);
        end
    endtask

    task automatic test_full_failure();
        int req_n = 0;
        int err_n = 0;
        int req_at[3] = '{-1, -1, -1};
        int err_at = -1;
        logic busy_at_err = 1'bx;
        apply_reset();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (req === 1'b1) begin
                if (req_n < 3) req_at[req_n] = cyc;
                req_n++;
            end
            if (err === 1'b1) begin
                err_n++;
                err_at      = cyc;
                busy_at_err = busy;
            end
            tick();
        end
        tests++;
        if (req_n != 3) begin
            fails++;
            $display("FAIL fail_req_count got %0d want 3", req_n);
        end
        tests++;
        if (req_at[0] != 0 || req_at[1] != 13 || req_at[2] != 26) begin
            fails++;
            $display("FAIL fail_req_spacing got %0d,%0d,%0d want 0,13,26",
                     req_at[0], req_at[1], req_at[2]);
        end
        tests++;
        if (err_n != 1 || err_at != 35 || busy_at_err !== 1'b0) begin
            fails++;
            $display("FAIL fail_err got n=%0d at=%0d busy=%b want n=1 at=35 busy=0",
                     err_n, err_at, busy_at_err);
        end
        tests++;
        if (timeout_cnt !== 16'd3 || grant_cnt !== 16'd0) begin
            fails++;
            $display("FAIL fail_counters tc=%0d gc=%0d want tc=3 gc=0",
                     timeout_cnt, grant_cnt);
        end
    endtask

    task automatic test_retry_success();
        apply_reset();
        start = 1'b1;
        tick();                      // attempt 1 REQ
        start = 1'b0;
        repeat (13) tick();          // attempt 2 REQ
        tests++;
        if (obs !== 5'b11000 || timeout_cnt !== 16'd1) begin
            fails++;
            $display("FAIL retry_req2 obs=%b tc=%0d want obs=11000 tc=1", obs, timeout_cnt);
        end
        repeat (8) tick();           // final WAIT cycle of attempt 2
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        tests++;
        if (obs !== 5'b00100 || grant_cnt !== 16'd1 || timeout_cnt !== 16'd1) begin
            fails++;
            $display("FAIL retry_done obs=%b gc=%0d tc=%0d want obs=00100 gc=1 tc=1",
                     obs, grant_cnt, timeout_cnt);
        end
        tick();
        tests++;
        if (obs !== 5'b00000 || timeout_cnt !== 16'd1) begin
            fails++;
            $display("FAIL retry_after obs=%b tc=%0d want obs=00000 tc=1", obs, timeout_cnt);
        end
    endtask

    task automatic test_stray_and_drop();
        apply_reset();
        gnt = 1'b1;                  // grant while idle
        tick();
        gnt = 1'b0;
        tests++;
        if (obs !== 5'b00001 || grant_cnt !== 16'd0 || timeout_cnt !== 16'd0) begin
            fails++;
            $display("FAIL stray_idle obs=%b gc=%0d tc=%0d want obs=00001 gc=0 tc=0",
                     obs, grant_cnt, timeout_cnt);
        end
        tick();
        tests++;
        if (obs !== 5'b00000) begin
            fails++;
            $display("FAIL stray_idle_clear obs=%b want 00000", obs);
        end
        start = 1'b1;
        tick();                      // REQ cycle
        start = 1'b0;
        gnt   = 1'b1;                // same-cycle grant in REQ
        tick();                      // WAIT 1
        gnt   = 1'b0;
        tests++;
        if (obs !== 5'b01001) begin
            fails++;
            $display("FAIL stray_req obs=%b want 01001", obs);
        end
        start = 1'b1;                // dropped: busy
        tick();                      // WAIT 2
        start = 1'b0;
        tests++;
        if (obs !== 5'b01000) begin
            fails++;
            $display("FAIL drop_wait2 obs=%b want 01000", obs);
        end
        tick();                      // WAIT 3
        tests++;
        if (obs !== 5'b01000) begin
            fails++;
            $display("FAIL drop_wait3 obs=%b want 01000", obs);
        end
        gnt = 1'b1;
        tick();                      // done cycle, state idle
        gnt = 1'b0;
        tests++;
        if (obs !== 5'b00100 || grant_cnt !== 16'd1) begin
            fails++;
            $display("FAIL drop_done obs=%b gc=%0d want obs=00100 gc=1", obs, grant_cnt);
        end
        start = 1'b1;                // start during done, plus stray gnt
        gnt   = 1'b1;
        tick();
        start = 1'b0;
        gnt   = 1'b0;
        tests++;
        if (obs !== 5'b11001 || grant_cnt !== 16'd1) begin
            fails++;
            $display("FAIL start_with_stray obs=%b gc=%0d want obs=11001 gc=1", obs, grant_cnt);
        end
    endtask

    task automatic test_midflight_reset();
        int bad = 0;
        apply_reset();
        start = 1'b1;
        tick();                      // attempt 1 REQ
        start = 1'b0;
        repeat (13) tick();          // attempt 2 REQ
        repeat (3) tick();           // attempt 2 WAIT 3
        tests++;
        if (obs !== 5'b01000 || timeout_cnt !== 16'd1) begin
            fails++;
            $display("FAIL mid_before obs=%b tc=%0d want obs=01000 tc=1", obs, timeout_cnt);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tests++;
        if (obs !== 5'b00000 || grant_cnt !== 16'd0 || timeout_cnt !== 16'd0) begin
            fails++;
            $display("FAIL mid_reset obs=%b gc=%0d tc=%0d want obs=00000 gc=0 tc=0",
                     obs, grant_cnt, timeout_cnt);
        end
        for (int i = 0; i < 12; i++) begin
            tick();
            if (obs !== 5'b00000) bad++;
        end
        tests++;
        if (bad != 0) begin
            fails++;
            $display("FAIL mid_quiet nonzero_cycles=%0d want 0", bad);
        end
        gnt = 1'b1;
        tick();
        gnt = 1'b0;
        tests++;
        if (obs !== 5'b00001 || grant_cnt !== 16'd0 || timeout_cnt !== 16'd0) begin
            fails++;
            $display("FAIL mid_stray obs=%b gc=%0d tc=%0d want obs=00001 gc=0 tc=0",
                     obs, grant_cnt, timeout_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_single_grant();
        test_full_failure();
        test_retry_success();
        test_stray_and_drop();
        test_midflight_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_req_gnt_initiator
